sprite_oam_dma: RTL and testbench
=================================

Name: sprite_oam_dma

Overview:
- AHB-Lite master that bulk-copies a sprite attribute table, 64 32-bit entries, from system memory into the sprite RAM AHB slave port.
- Replaces 64 CPU store instructions per frame.
- Sits on the system bus matrix as a second master and drives the same AHB slave protocol that the sprite RAM interface responds to.
- Triggered by a start pulse from a CPU control register; reports busy, done and error.

Parameters:
- WORD_COUNT, 64, number of 32-bit words copied per transfer; equals sprite count.
- CNT_W, 7, word-counter width; must satisfy 2^CNT_W > WORD_COUNT.

Ports:
- clk_50MHz  input  1  bus clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle pulse; begins a transfer when idle.
- src_base  input  32  byte address of source table; sampled at start; bits[1:0] forced to 0.
- dst_base  input  32  byte address of sprite RAM window; sampled at start; bits[1:0] forced to 0.
- vblank  input  1  high while VGA is outside the game window; used only with the optional feature.
- busy  output  1  high from accepted start until done.
- done  output  1  1-cycle pulse at end of a transfer, whether it completes or aborts.
- err  output  1  sticky error flag; cleared by the next accepted start.
- HADDR  output  32  AHB address.
- HTRANS  output  2  AHB transfer type; only IDLE=2'b00 and NONSEQ=2'b10 are used.
- HSIZE  output  3  constant 3'b010 (word).
- HWRITE  output  1  AHB write flag.
- HWDATA  output  32  AHB write data.
- HRDATA  input  32  AHB read data.
- HREADY  input  1  AHB ready.
- HRESP  input  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset values: busy=0, done=0, err=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, counter=0, state=IDLE.
- Reset is honoured mid-transfer. The bus returns to IDLE immediately and no partial state is retained.
- The master is non-pipelined: it never overlaps an address phase with another transfer's data phase. HTRANS is IDLE during every data phase.
- States:
  - IDLE: on start, latch src/dst, set counter=0, clear err, set busy=1, go to RD_A. A start while busy is ignored.
  - RD_A: drive HTRANS=NONSEQ, HWRITE=0, HADDR=src+4*counter. When HREADY=1, go to RD_D.
  - RD_D: when HREADY=1 and HRESP=0, capture HRDATA into the hold register and go to WR_A.
  - WR_A: drive HTRANS=NONSEQ, HWRITE=1, HADDR=dst+4*counter. When HREADY=1, go to WR_D.
  - WR_D: drive HWDATA=hold register, held stable until HREADY=1. When HREADY=1 and HRESP=0: if counter==WORD_COUNT-1, go to FIN; else increment counter and go to RD_A.
  - FIN: for one cycle done=1 and busy=0, then go to IDLE.
- Error handling: HRESP=1 in RD_D or WR_D sets err=1. HTRANS stays IDLE across both error-response cycles. The block waits for the HREADY=1 cycle of the error response, then goes to FIN, so the transfer aborts and the remaining words are not copied.
- Address arithmetic is 32-bit modulo 2^32. Wrap past 0xFFFFFFFC is permitted and unflagged.
- Minimum latency is 4 cycles per word. With zero wait states, done pulses 4*WORD_COUNT+1 cycles after start, which is 257 cycles for 64 words.
- Wait states (HREADY=0) stretch the current phase. All outputs are held stable while stretched.
- A start in the same cycle as FIN is ignored; start is accepted only in IDLE.

Optional Feature:
- Macro: SPRITE_DMA_VBLANK_SYNC_EN.
- Defined:
  - An accepted start moves to a WAIT_VB state with busy=1.
  - The first bus access begins on the first cycle vblank=1, or immediately if vblank is already 1.
  - This keeps sprite RAM from being rewritten mid-frame and prevents tearing.
  - Reset in WAIT_VB returns to IDLE.
- Undefined: the vblank input is ignored and IDLE goes directly to RD_A.

Test Plan:
- Zero-wait copy: src=0x2000_0000 holds 0x1000+i for i=0..63, dst=0x5000_0000, pulse start. Required: sprite RAM word i = 0x1000+i; done pulses 257 cycles after start; err=0.
- Wait states: slave inserts 2 HREADY=0 cycles on every data phase. Required: HADDR, HWRITE and HWDATA are stable while stretched; data is correct; total cycles = 64*(4+4)+1 = 513.
- Error abort: HRESP=ERROR on the read of word 10. Required: err=1; done pulses; HTRANS=IDLE through both error cycles; words 10..63 are not written; word 9 is written.
- Ignored start: pulse start again at cycle 50. Required: HADDR sequence is unaffected and only one done occurs. A later start after done clears err and re-runs the copy.
- Async reset: assert rst during WR_D of word 30. Required: all outputs are at reset values within the same cycle and no further NONSEQ occurs. A later start copies all 64 words.
- With SPRITE_DMA_VBLANK_SYNC_EN: start while vblank=0, raise vblank 100 cycles later. Required: busy=1 and HTRANS=IDLE for those 100 cycles, and the first NONSEQ appears in the cycle vblank=1 is sampled.

Source files
------------

// File: rtl/sprite_oam_dma_if.sv
// sprite_oam_dma_if -- AHB-Lite bus bundle between the sprite OAM DMA master
// and the slave it talks to (bus matrix / sprite RAM port).
//
// Signals:
//   HADDR  [31:0] byte address of the current address phase
//   HTRANS [1:0]  2'b00 IDLE, 2'b10 NONSEQ (no other codes are used)
//   HSIZE  [2:0]  transfer size, always word (3'b010)
//   HWRITE        1 = write, 0 = read
//   HWDATA [31:0] write data, valid during a write data phase
//   HRDATA [31:0] read data, valid when HREADY=1 in a read data phase
//   HREADY        slave ready; 0 stretches the current phase
//   HRESP         0 = OKAY, 1 = ERROR
//
// Handshake: an address phase is accepted on the rising edge where
// HTRANS=NONSEQ and HREADY=1; the following cycles form its data phase, which
// completes on the first rising edge with HREADY=1. The master holds every
// output stable while HREADY=0 and never issues a new address during a data
// phase. An ERROR response is two cycles: HRESP=1 with HREADY=0, then HRESP=1
// with HREADY=1.
interface sprite_oam_dma_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/sprite_oam_dma.sv
// sprite_oam_dma -- AHB-Lite master that copies the sprite attribute table
// (WORD_COUNT 32-bit words) from system memory into the sprite RAM window.
// Each word is one non-pipelined read followed by one write, so a word costs
// at least 4 cycles (RD_A, RD_D, WR_A, WR_D).
//
// Optional build macro SPRITE_DMA_VBLANK_SYNC_EN: when defined, an accepted
// start waits in WAIT_VB until vblank=1 before the first bus access, so sprite
// RAM is only rewritten outside the visible game window. When undefined, the
// vblank input is ignored.
//
// Ports:
//   clk_50MHz        bus clock, rising edge
//   rst              asynchronous active-high reset
//   start            1-cycle pulse, accepted only in IDLE
//   src_base[31:0]   source table byte address (latched at start, [1:0] dropped)
//   dst_base[31:0]   sprite RAM byte address (latched at start, [1:0] dropped)
//   vblank           vertical blank indicator (optional feature only)
//   busy             high from accepted start until the FIN cycle
//   done             1-cycle pulse in FIN (completion or abort)
//   err              sticky bus-error flag, cleared by the next accepted start
//   state_dbg[2:0]   current FSM state encoding
//   bus              AHB-Lite master modport
module sprite_oam_dma #(
  parameter int WORD_COUNT = 64,
  parameter int CNT_W      = 7
) (
  input  logic                    clk_50MHz,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             src_base,
  input  logic [31:0]             dst_base,
  input  logic                    vblank,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              state_dbg,
  sprite_oam_dma_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_A    = 3'd1,
    S_RD_D    = 3'd2,
    S_WR_A    = 3'd3,
    S_WR_D    = 3'd4,
    S_FIN     = 3'd5,
    S_WAIT_VB = 3'd6
  } state_t;

  localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;
  localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(WORD_COUNT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      hold_q;
  logic             err_q;
  logic [31:0]      word_off;
  logic             accept;
  logic             data_phase;

`ifndef SPRITE_DMA_VBLANK_SYNC_EN
  logic vblank_unused;
  assign vblank_unused = vblank;
`endif

  assign accept     = (state == S_IDLE) && start;
  assign data_phase = (state == S_RD_D) || (state == S_WR_D);
  // Byte offset of the current word; the add below wraps modulo 2^32.
  assign word_off   = 32'(cnt) << 2;

  // State register and datapath registers.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        src_q <= {src_base[31:2], 2'b00};
        dst_q <= {dst_base[31:2], 2'b00};
        cnt   <= '0;
        err_q <= 1'b0;
      end
      if (state == S_RD_D && bus.HREADY && !bus.HRESP) begin
        hold_q <= bus.HRDATA;
      end
      if (state == S_WR_D && bus.HREADY && !bus.HRESP && cnt != LAST_IDX) begin
        cnt <= cnt + 1'b1;
      end
      // Flag on the first ERROR cycle; the abort itself waits for HREADY=1.
      if (data_phase && bus.HRESP) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef SPRITE_DMA_VBLANK_SYNC_EN
          state_n = vblank ? S_RD_A : S_WAIT_VB;
`else
          state_n = S_RD_A;
`endif
        end
      end
`ifdef SPRITE_DMA_VBLANK_SYNC_EN
      S_WAIT_VB: begin
        if (vblank) state_n = S_RD_A;
      end
`endif
      S_RD_A: begin
        if (bus.HREADY) state_n = S_RD_D;
      end
      S_RD_D: begin
        if (bus.HREADY) state_n = bus.HRESP ? S_FIN : S_WR_A;
      end
      S_WR_A: begin
        if (bus.HREADY) state_n = S_WR_D;
      end
      S_WR_D: begin
        if (bus.HREADY) begin
          if (bus.HRESP || cnt == LAST_IDX) state_n = S_FIN;
          else                              state_n = S_RD_A;
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from registered state only, so they are stable
  // for the whole of a stretched phase and drop to reset values as soon as
  // rst clears the state register.
  always_comb begin
    bus.HTRANS = HTRANS_IDLE;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HWDATA = '0;
    case (state)
      S_RD_A: begin
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = src_q + word_off;
      end
      S_RD_D: begin
        bus.HADDR  = src_q + word_off;
      end
      S_WR_A: begin
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = dst_q + word_off;
        bus.HWRITE = 1'b1;
      end
      S_WR_D: begin
        bus.HADDR  = dst_q + word_off;
        bus.HWRITE = 1'b1;
        bus.HWDATA = hold_q;
      end
      default: ;
    endcase
  end

  assign bus.HSIZE = 3'b010;
  assign busy      = (state != S_IDLE) && (state != S_FIN);
  assign done      = (state == S_FIN);
  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_sprite_oam_dma.sv
module tb_sprite_oam_dma;

  // ---------------- clock / reset ----------------
  logic clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  logic        rst;
  logic        start;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic        vblank;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  sprite_oam_dma_if bus();

  sprite_oam_dma dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .vblank    (vblank),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg),
    .bus       (bus.master)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];          // {write address, write data}
  logic [31:0] src_mem[64];
  logic [31:0] cur_src;           // aligned source base of the running copy
  int wait_cfg    = 0;            // HREADY=0 cycles per data phase
  int err_rd_word = -1;           // word index whose read gets ERROR
  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int wr_cnt      = 0;
  int nonseq_cnt  = 0;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ---------------- done monitor ----------------
  initial begin
    forever begin
      @(negedge clk_50MHz);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- AHB slave model + write monitor ----------------
  // Works on the falling edge: looks at what the master presents this cycle,
  // and drives HREADY/HRESP/HRDATA for the coming rising edge.
  initial begin
    bit          in_data;
    bit          d_write;
    bit          d_err;
    bit          first;
    int          d_wait;
    int          err_step;
    logic [31:0] d_addr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_write;
    bit          prev_ready;
    bit          prev_nonseq;
    logic [31:0] prev_haddr;
    logic        prev_hwrite;
    logic [31:0] off;
    logic [63:0] e;
    in_data = 0; d_write = 0; d_err = 0; first = 0; d_wait = 0; err_step = 0;
    d_addr = '0; s_addr = '0; s_wdata = '0; s_write = 1'b0;
    prev_ready = 0; prev_nonseq = 0; prev_haddr = '0; prev_hwrite = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    forever begin
      @(negedge clk_50MHz);
      if (rst) begin
        in_data     = 0;
        prev_ready  = 0;
        prev_nonseq = 0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;
        bus.HRDATA  = '0;
      end else begin
        if (prev_ready) begin
          in_data = 0;
          if (prev_nonseq) begin
            in_data  = 1;
            d_addr   = prev_haddr;
            d_write  = prev_hwrite;
            d_wait   = wait_cfg;
            d_err    = !prev_hwrite && (err_rd_word >= 0) &&
                       (prev_haddr == cur_src + 32'(4 * err_rd_word));
            err_step = 0;
            first    = 1;
          end
        end
        if (in_data) begin
          check("htrans_idle_in_data", bus.HTRANS, 2'b00);
          if (first) begin
            s_addr = bus.HADDR; s_write = bus.HWRITE; s_wdata = bus.HWDATA;
            first  = 0;
          end else begin
            check("stretch_haddr", bus.HADDR, s_addr);
            check("stretch_hwrite", bus.HWRITE, s_write);
            check("stretch_hwdata", bus.HWDATA, s_wdata);
          end
          if (d_err) begin
            bus.HRESP  = 1'b1;
            bus.HREADY = (err_step != 0);
            err_step++;
          end else if (d_wait > 0) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = 1'b0;
            d_wait--;
          end else begin
            bus.HREADY = 1'b1;
            bus.HRESP  = 1'b0;
            if (d_write) begin
              wr_cnt++;
              if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h:%0h want none", d_addr, bus.HWDATA);
              end else begin
                e = exp_q.pop_front();
                check("write", {d_addr, bus.HWDATA}, e);
              end
            end else begin
              off = (d_addr - cur_src) >> 2;
              bus.HRDATA = src_mem[off[5:0]];
            end
          end
        end else begin
          bus.HREADY = 1'b1;
          bus.HRESP  = 1'b0;
        end
        prev_ready  = bus.HREADY;
        prev_nonseq = (bus.HTRANS == 2'b10);
        prev_haddr  = bus.HADDR;
        prev_hwrite = bus.HWRITE;
        if (bus.HTRANS == 2'b10) nonseq_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_src(input logic [31:0] base_val, input logic [31:0] step);
    for (int i = 0; i < 64; i++) src_mem[i] = base_val + step * 32'(i);
  endtask

  task automatic push_exp(input logic [31:0] dst_al, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({dst_al + 32'(4 * i), src_mem[i]});
  endtask

  // Issues one start pulse right after a rising edge; returns the cycle stamp.
  task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, output int sc);
    @(posedge clk_50MHz);
    #1;
    start    = 1'b1;
    src_base = src;
    dst_base = dst;
    sc       = cyc;
    @(posedge clk_50MHz);
    #1;
    start    = 1'b0;
    // Bases must have been latched; scramble the inputs.
    src_base = $urandom;
    dst_base = $urandom;
    check("busy_after_start", busy, 1'b1);
    check("err_cleared_on_start", err, 1'b0);
  endtask

  task automatic do_transfer(input string name, input logic [31:0] src, input logic [31:0] dst,
                             input int n_exp, input int waits, input int errw,
                             input int exp_lat, input bit exp_err, input int restart_at);
    int  sc;
    int  d0;
    bit  seen;
    cur_src     = {src[31:2], 2'b00};
    wait_cfg    = waits;
    err_rd_word = errw;
    push_exp({dst[31:2], 2'b00}, n_exp);
    d0 = done_cnt;
    pulse_start(src, dst, sc);
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk_50MHz);
      start = (restart_at > 0) && (cyc - sc == restart_at);
      if (done_cnt != d0) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done", name);
    end else begin
      check({name, "_latency"}, 64'(done_cyc - sc), 64'(exp_lat));
      check({name, "_err"}, err, exp_err);
    end
    repeat (20) @(negedge clk_50MHz);
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_busy_idle"}, busy, 1'b0);
    check({name, "_missing_writes"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    err_rd_word = -1;
    wait_cfg    = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_err"}, err, 1'b0);
    check({name, "_htrans"}, bus.HTRANS, 2'b00);
    check({name, "_haddr"}, bus.HADDR, 32'h0);
    check({name, "_hwrite"}, bus.HWRITE, 1'b0);
    check({name, "_hwdata"}, bus.HWDATA, 32'h0);
    check({name, "_state"}, state_dbg, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  sc;
    int  w0;
    int  n0;
    bit  hit;
    rst      = 1'b1;
    start    = 1'b0;
    src_base = '0;
    dst_base = '0;
    vblank   = 1'b0;
    cur_src  = '0;
    fill_src(32'h0000_1000, 32'h1);
    repeat (3) @(negedge clk_50MHz);
    check_reset_outputs("reset");
    check("reset_hsize", bus.HSIZE, 3'b010);
    @(posedge clk_50MHz);
    #1 rst = 1'b0;

    // Zero-wait copy with a second start at cycle 50 that must be ignored.
    do_transfer("zero_wait", 32'h2000_0000, 32'h5000_0000, 64, 0, -1, 257, 1'b0, 50);

    // Two wait states on every data phase.
    fill_src(32'h0BAD_0000, 32'h0001_0003);
    do_transfer("wait_states", 32'h2000_0100, 32'h5000_0000, 64, 2, -1, 513, 1'b0, 0);

    // ERROR on the read of word 10: words 0..9 written, then abort.
    fill_src(32'h0000_1000, 32'h1);
    do_transfer("error_abort", 32'h2000_0000, 32'h5000_0000, 10, 0, 10, 44, 1'b1, 0);

    // Rerun after error: err clears, unaligned bases, source wraps past 2^32.
    fill_src(32'hC0DE_0000, 32'h0101);
    do_transfer("rerun_wrap", 32'hFFFF_FFF3, 32'h5000_0002, 64, 0, -1, 257, 1'b0, 0);

    // Asynchronous reset during the write data phase of word 30.
    fill_src(32'h0000_1000, 32'h1);
    cur_src = 32'h2000_0000;
    push_exp(32'h5000_0000, 30);
    w0 = wr_cnt;
    pulse_start(32'h2000_0000, 32'h5000_0000, sc);
    hit = 0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk_50MHz);
      if (wr_cnt - w0 == 30 && bus.HTRANS == 2'b10 && bus.HWRITE) hit = 1;
    end
    check("rst_reach_word30", hit, 1'b1);
    @(posedge clk_50MHz);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    n0 = nonseq_cnt;
    repeat (3) @(posedge clk_50MHz);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk_50MHz);
    check("rst_no_nonseq", 64'(nonseq_cnt - n0), 64'd0);
    check("rst_words_written", 64'(wr_cnt - w0), 64'd30);
    check("rst_missing_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    do_transfer("after_rst", 32'h2000_0000, 32'h5000_0000, 64, 0, -1, 257, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound in case the DUT wedges outside any bounded loop.
  initial begin
    #4000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
